// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM arbiter: FSM states and client indices.
package ram_arb_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } arb_state_e;

    // Client index doubles as the bit position in the req/gnt vectors.
    typedef enum logic {
        CLI_A = 1'b0,
        CLI_B = 1'b1
    } cli_e;

    localparam int NUM_CLI = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// client that did not win most recently.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [NUM_CLI-1:0] req,
    input  logic               last,
    output logic [NUM_CLI-1:0] gnt
);

    logic a_was_last;

    assign a_was_last = (last == CLI_A);

    assign gnt[CLI_A] = req[CLI_A] & (~req[CLI_B] | ~a_was_last);
    assign gnt[CLI_B] = req[CLI_B] & (~req[CLI_A] |  a_was_last);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two clients onto one external 1R1W RAM with registered read data,
// after an optional post-reset zero-fill sweep of every address.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5,
    parameter bit INIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic               we_a,
    input  logic               we_b,
    input  logic [A_WIDTH-1:0] addr_a,
    input  logic [A_WIDTH-1:0] addr_b,
    input  logic [D_WIDTH-1:0] wdata_a,
    input  logic [D_WIDTH-1:0] wdata_b,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               rvalid_a,
    output logic               rvalid_b,
    output logic [D_WIDTH-1:0] rdata,
    output logic               init_done,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_waddr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic [A_WIDTH-1:0] mem_raddr,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = {A_WIDTH{1'b1}};

    arb_state_e          state;
    cli_e                last;
    logic [A_WIDTH-1:0]  init_cnt;
    logic [A_WIDTH-1:0]  raddr_q;
    logic [NUM_CLI-1:0]  req;
    logic [NUM_CLI-1:0]  rr_gnt;
    logic [NUM_CLI-1:0]  gnt;
    logic                live;
    logic                win_b;
    logic                win_we;
    logic [A_WIDTH-1:0]  win_addr;
    logic [D_WIDTH-1:0]  win_wdata;
    logic                wr_gnt;
    logic                rd_gnt;

    assign req  = {req_b, req_a};
    // Async reset must silence the combinational outputs immediately too.
    assign live = rst_n;

    rr_arb2 u_rr (
        .req  (req),
        .last (last),
        .gnt  (rr_gnt)
    );

    assign gnt   = (live && state == READY) ? rr_gnt : '0;
    assign gnt_a = gnt[CLI_A];
    assign gnt_b = gnt[CLI_B];

    assign win_b     = gnt[CLI_B];
    assign win_we    = win_b ? we_b    : we_a;
    assign win_addr  = win_b ? addr_b  : addr_a;
    assign win_wdata = win_b ? wdata_b : wdata_a;
    assign wr_gnt    = (|gnt) &  win_we;
    assign rd_gnt    = (|gnt) & ~win_we;

    always_comb begin
        mem_we    = wr_gnt;
        mem_waddr = win_addr;
        mem_wdata = win_wdata;
        if (live && state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = '0;
        end
    end

    // Read address follows the granted read, otherwise parks on the last one.
    assign mem_raddr = rd_gnt ? win_addr : raddr_q;
    assign rdata     = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT_EN ? INIT : READY;
            init_cnt  <= '0;
            init_done <= !INIT_EN;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= CLI_B;
            raddr_q  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= rd_gnt & ~win_b;
            rvalid_b <= rd_gnt &  win_b;
            if (|gnt)
                last <= win_b ? CLI_B : CLI_A;
            if (rd_gnt)
                raddr_q <= win_addr;
        end
    end

endmodule
